// File: rtl/fios_operand_feeder_if.sv
// Bundles the host load stream and the multiplier-facing signals of the
// FIOS operand feeder.
//   slave  : the feeder's side (takes host words and multiplier strobes, drives operands)
//   master : the host/multiplier side
// Signal names keep the feeder's point of view (_i = into feeder, _o = out of feeder).
interface fios_operand_feeder_if #(
  parameter int unsigned WORD_WIDTH = 17,
  parameter int unsigned PE_NB      = 8
);
  logic                        load_valid_i;
  logic [WORD_WIDTH-1:0]       load_data_i;
  logic                        load_ready_o;
  logic                        go_i;
  logic                        busy_o;
  logic                        start_o;
  logic [PE_NB*WORD_WIDTH-1:0] a_o;
  logic [WORD_WIDTH-1:0]       b_o;
  logic [WORD_WIDTH-1:0]       p_o;
  logic                        a_shift_i;
  logic                        b_fetch_i;
  logic                        p_fetch_i;
  logic                        done_i;

  modport slave (
    input  load_valid_i, load_data_i, go_i, a_shift_i, b_fetch_i, p_fetch_i, done_i,
    output load_ready_o, busy_o, start_o, a_o, b_o, p_o
  );

  modport master (
    output load_valid_i, load_data_i, go_i, a_shift_i, b_fetch_i, p_fetch_i, done_i,
    input  load_ready_o, busy_o, start_o, a_o, b_o, p_o
  );
endinterface

// File: rtl/fios_operand_feeder.sv
// Operand buffer and sequencer in front of the FIOS multiplier.
// Collects 3*s host words (a, then b, then p), waits for go_i, pulses start_o
// for one cycle and then serves operands until done_i:
//   a_o : PE_NB-word window of a, advanced by a_shift_i, wraps after the last window
//   b_o : b[b_ptr], stepped by b_fetch_i (wraps at s-1)
//   p_o : p[p_ptr], stepped by p_fetch_i (wraps at s-1)
// Ports: clock_i, reset_n_i (async, active low), bus (fios_operand_feeder_if.slave).
module fios_operand_feeder #(
  parameter int unsigned s          = 8,
  parameter int unsigned WORD_WIDTH = 17,
  parameter int unsigned PE_NB      = 8
) (
  input logic                  clock_i,
  input logic                  reset_n_i,
  fios_operand_feeder_if.slave bus
);
  localparam int unsigned NumWords = 3 * s;
  localparam int unsigned NumWin   = (s + PE_NB - 1) / PE_NB;
  localparam int unsigned CntW     = $clog2(NumWords);
  localparam int unsigned PtrW     = $clog2(s);
  localparam int unsigned WinW     = $clog2(NumWin + 1);

  localparam logic [CntW-1:0] LastWord = CntW'(NumWords - 1);
  localparam logic [CntW-1:0] BBase    = CntW'(s);
  localparam logic [CntW-1:0] PBase    = CntW'(2 * s);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(s - 1);
  localparam logic [WinW-1:0] LastWin  = WinW'(NumWin - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StReady, StLaunch, StRun} state_e;

  state_e                          state_q, state_d;
  logic [CntW-1:0]                 cnt_q, cnt_d;
  logic [WinW-1:0]                 win_q, win_d;
  logic [PtrW-1:0]                 b_ptr_q, b_ptr_d;
  logic [PtrW-1:0]                 p_ptr_q, p_ptr_d;
  logic [s-1:0][WORD_WIDTH-1:0]    a_q, b_q, p_q;
  logic                            load_ready;
  logic                            accept;
  int unsigned                     a_idx;

  assign load_ready = (state_q == StIdle) || (state_q == StLoad);
  assign accept     = bus.load_valid_i & load_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    b_ptr_d = b_ptr_q;
    p_ptr_d = p_ptr_q;

    // Wrapping at the last word also clears the counter on entry to StReady.
    if (accept) begin
      cnt_d = (cnt_q == LastWord) ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      StIdle:   if (accept) state_d = StLoad;
      StLoad:   if (accept && (cnt_q == LastWord)) state_d = StReady;
      StReady:  if (bus.go_i) state_d = StLaunch;
      StLaunch: state_d = StRun;
      StRun: begin
        // done_i takes priority over any shift/fetch in the same cycle.
        if (bus.done_i) begin
          state_d = StIdle;
          win_d   = '0;
          b_ptr_d = '0;
          p_ptr_d = '0;
        end else begin
          if (bus.a_shift_i) win_d   = (win_q == LastWin) ? '0 : win_q + 1'b1;
          if (bus.b_fetch_i) b_ptr_d = (b_ptr_q == LastPtr) ? '0 : b_ptr_q + 1'b1;
          if (bus.p_fetch_i) p_ptr_d = (p_ptr_q == LastPtr) ? '0 : p_ptr_q + 1'b1;
        end
      end
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      win_q   <= '0;
      b_ptr_q <= '0;
      p_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      b_ptr_q <= b_ptr_d;
      p_ptr_q <= p_ptr_d;
    end
  end

  // Word index selects the destination buffer: a, then b, then p.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
    end else if (accept) begin
      if (cnt_q < BBase) begin
        a_q[PtrW'(cnt_q)] <= bus.load_data_i;
      end else if (cnt_q < PBase) begin
        b_q[PtrW'(cnt_q - BBase)] <= bus.load_data_i;
      end else begin
        p_q[PtrW'(cnt_q - PBase)] <= bus.load_data_i;
      end
    end
  end

  // Window slots past the end of a read as zero (last window may be partial).
  always_comb begin
    bus.a_o = '0;
    a_idx   = 0;
    for (int unsigned k = 0; k < PE_NB; k++) begin
      a_idx = 32'(win_q) * PE_NB + k;
      if (a_idx < s) begin
        bus.a_o[k*WORD_WIDTH +: WORD_WIDTH] = a_q[PtrW'(a_idx)];
      end
    end
  end

  assign bus.b_o          = b_q[b_ptr_q];
  assign bus.p_o          = p_q[p_ptr_q];
  assign bus.load_ready_o = load_ready;
  assign bus.busy_o       = (state_q == StLaunch) || (state_q == StRun);
  assign bus.start_o      = (state_q == StLaunch);
endmodule
